// File: rtl/cmos_frame_writer.sv
// Camera-capture write engine: synchronises the raw CMOS sensor bus into clk_i,
// packs bytes into pixels and writes whole frames into single or double-buffered VRAM.
module cmos_frame_writer #(
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 240,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int NUM_BUFFERS     = 2,
    localparam int PIXEL_WIDTH    = 8 * BYTES_PER_PIXEL,
    localparam int FRAME_PIXELS   = H_ACTIVE * V_ACTIVE,
    localparam int ADDR_WIDTH     = $clog2(FRAME_PIXELS * NUM_BUFFERS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   pclk_cmos_i,
    input  logic                   vsync_cmos_i,
    input  logic                   href_cmos_i,
    input  logic [7:0]             pixel_data_cmos_i,
    output logic                   wr_en_o,
    output logic [ADDR_WIDTH-1:0]  wr_addr_o,
    output logic [PIXEL_WIDTH-1:0] wr_data_o,
    output logic                   rd_buffer_o,
    output logic                   frame_done_o,
    output logic                   frame_error_o,
    output logic [15:0]            frame_count_o
);

    localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC,
        ST_BLANK,
        ST_ACTIVE
    } state_t;

    state_t state, state_next;

    logic [2:0]             pclk_s;
    logic [2:0]             vsync_s;
    logic [2:0]             href_s;
    logic [7:0]             data_s1, data_s2;
    logic                   pclk_rise, vsync_rise, vsync_fall, href_fall;
    logic                   start_frame, end_frame, capture;
    logic [CNT_W-1:0]       pixel_cnt;
    logic [1:0]             byte_phase;
    logic                   overflow;
    logic [PIXEL_WIDTH-1:0] pixel_sr, sr_next;
    logic [ADDR_WIDTH-1:0]  buf_base;
    logic                   wbuf;

    // Index 1 is the second sync stage; index 2 is the previous value for edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pclk_s  <= '0;
            vsync_s <= '0;
            href_s  <= '0;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            pclk_s  <= {pclk_s[1:0], pclk_cmos_i};
            vsync_s <= {vsync_s[1:0], vsync_cmos_i};
            href_s  <= {href_s[1:0], href_cmos_i};
            data_s1 <= pixel_data_cmos_i;
            data_s2 <= data_s1;
        end
    end

    assign pclk_rise  = pclk_s[1] & ~pclk_s[2];
    assign vsync_rise = vsync_s[1] & ~vsync_s[2];
    assign vsync_fall = ~vsync_s[1] & vsync_s[2];
    assign href_fall  = ~href_s[1] & href_s[2];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_WAIT_VSYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            ST_WAIT_VSYNC: begin
                if (vsync_rise) state_next = ST_BLANK;
            end
            ST_BLANK: begin
                if (vsync_fall && enable_i) begin
                    state_next  = ST_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise) begin
                    state_next = ST_BLANK;
                    end_frame  = 1'b1;
                end
            end
            default: state_next = ST_WAIT_VSYNC;
        endcase
    end

    // A vsync edge in the same cycle wins over the byte strobe.
    assign capture  = (state == ST_ACTIVE) && !vsync_rise && pclk_rise && href_s[1];
    assign sr_next  = (pixel_sr << 8) | PIXEL_WIDTH'(data_s2);
    assign wbuf     = (NUM_BUFFERS == 2) ? ~rd_buffer_o : 1'b0;
    assign buf_base = wbuf ? ADDR_WIDTH'(FRAME_PIXELS) : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            rd_buffer_o   <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_error_o <= 1'b0;
            frame_count_o <= '0;
            pixel_cnt     <= '0;
            byte_phase    <= '0;
            overflow      <= 1'b0;
            pixel_sr      <= '0;
        end else begin
            wr_en_o       <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_error_o <= 1'b0;
            if (start_frame) begin
                pixel_cnt  <= '0;
                byte_phase <= '0;
                overflow   <= 1'b0;
            end else if (end_frame) begin
                if (pixel_cnt == CNT_W'(FRAME_PIXELS) && !overflow) begin
                    frame_done_o  <= 1'b1;
                    frame_count_o <= frame_count_o + 16'd1;
                    if (NUM_BUFFERS == 2) rd_buffer_o <= ~rd_buffer_o;
                end else begin
                    frame_error_o <= 1'b1;
                end
            end else if (capture) begin
                pixel_sr <= sr_next;
                if (byte_phase == 2'(BYTES_PER_PIXEL - 1)) begin
                    byte_phase <= '0;
                    if (pixel_cnt == CNT_W'(FRAME_PIXELS)) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= buf_base + ADDR_WIDTH'(pixel_cnt);
                        wr_data_o <= sr_next;
                        pixel_cnt <= pixel_cnt + 1'b1;
                    end
                end else begin
                    byte_phase <= byte_phase + 2'd1;
                end
            end else if (href_fall) begin
                byte_phase <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cmos_frame_writer.sv
// Directed bench: a 4x2 RGB565 double-buffered writer and a 4x2 grey single-buffered writer
// share the sensor stimulus; written pixels and commit pulses are collected and compared.
module tb_cmos_frame_writer;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic enable_i = 1'b0;
    logic pclk = 1'b0, vsync = 1'b0, href = 1'b0;
    logic [7:0] data = '0;

    logic        wr_en_a, rd_buffer_a, frame_done_a, frame_error_a;
    logic [3:0]  wr_addr_a;
    logic [15:0] wr_data_a, frame_count_a;
    logic        wr_en_b, rd_buffer_b, frame_done_b, frame_error_b;
    logic [2:0]  wr_addr_b;
    logic [7:0]  wr_data_b;
    logic [15:0] frame_count_b;

    always #5 clk = ~clk;

    cmos_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .BYTES_PER_PIXEL(2), .NUM_BUFFERS(2)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .pclk_cmos_i(pclk), .vsync_cmos_i(vsync), .href_cmos_i(href), .pixel_data_cmos_i(data),
        .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a), .rd_buffer_o(rd_buffer_a),
        .frame_done_o(frame_done_a), .frame_error_o(frame_error_a), .frame_count_o(frame_count_a));

    cmos_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .BYTES_PER_PIXEL(1), .NUM_BUFFERS(1)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .pclk_cmos_i(pclk), .vsync_cmos_i(vsync), .href_cmos_i(href), .pixel_data_cmos_i(data),
        .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b), .rd_buffer_o(rd_buffer_b),
        .frame_done_o(frame_done_b), .frame_error_o(frame_error_b), .frame_count_o(frame_count_b));

    int n_checks = 0;
    int n_fail = 0;
    logic [3:0]  wa_addr[$];
    logic [15:0] wa_data[$];
    logic [2:0]  wb_addr[$];
    logic [7:0]  wb_data[$];
    logic [15:0] exp_q[$];
    int done_a, err_a, done_b, err_b;
    int k;
    logic [7:0] prev_byte;

    // Observe away from the active edge; a strobe held two cycles shows up as an extra write.
    always @(negedge clk) begin
        if (wr_en_a) begin wa_addr.push_back(wr_addr_a); wa_data.push_back(wr_data_a); end
        if (wr_en_b) begin wb_addr.push_back(wr_addr_b); wb_data.push_back(wr_data_b); end
        if (frame_done_a)  done_a++;
        if (frame_error_a) err_a++;
        if (frame_done_b)  done_b++;
        if (frame_error_b) err_b++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
        exp_q.delete();
        done_a = 0; err_a = 0; done_b = 0; err_b = 0; k = 0;
    endtask

    task automatic pclk_cycle(input logic [7:0] b, input logic h);
        pclk = 1'b0; data = b; href = h;
        clks(3);
        pclk = 1'b1;
        clks(3);
    endtask

    // Bytes follow 0x12, 0x34, 0x56, ...; expected pixels are whole groups within one line.
    task automatic send_line(input int nbytes, input int bpp);
        for (int j = 0; j < nbytes; j++) begin
            logic [7:0] b;
            b = 8'h12 + 8'(k) * 8'h22;
            k++;
            pclk_cycle(b, 1'b1);
            if (bpp == 1) exp_q.push_back({8'h00, b});
            else if (j % 2 == 1) exp_q.push_back({prev_byte, b});
            prev_byte = b;
        end
        pclk_cycle(8'h00, 1'b0);
        pclk_cycle(8'h00, 1'b0);
        pclk = 1'b0;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1; clks(12);
        vsync = 1'b0; clks(12);
    endtask

    task automatic test_reset();
        reset_i = 1'b1; enable_i = 1'b1;
        clks(3);
        n_checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a, rd_buffer_a, frame_done_a, frame_error_a, frame_count_a} !== '0)
            begin n_fail++; $display("FAIL reset_outputs_a: got fc=%h rd=%b en=%b, expected all 0", frame_count_a, rd_buffer_a, wr_en_a); end
        n_checks++;
        if ({wr_en_b, wr_addr_b, wr_data_b, rd_buffer_b, frame_done_b, frame_error_b, frame_count_b} !== '0)
            begin n_fail++; $display("FAIL reset_outputs_b: got fc=%h rd=%b en=%b, expected all 0", frame_count_b, rd_buffer_b, wr_en_b); end
        reset_i = 1'b0;
        clks(2);
        clear_obs();
        for (int i = 0; i < 10; i++) pclk_cycle(8'hA5, 1'b1);
        href = 1'b0; pclk = 1'b0;
        clks(4);
        n_checks++;
        if (wa_addr.size() + wb_addr.size() != 0)
            begin n_fail++; $display("FAIL idle_no_writes: got %0d writes, expected 0", wa_addr.size() + wb_addr.size()); end
        n_checks++;
        if ({rd_buffer_a, frame_count_a, done_a[0], err_a[0]} !== '0)
            begin n_fail++; $display("FAIL idle_outputs: got rd=%b fc=%0d done=%0d err=%0d, expected 0", rd_buffer_a, frame_count_a, done_a, err_a); end
    endtask

    task automatic test_full_frame();
        vsync_pulse();
        clear_obs();
        send_line(8, 2); send_line(8, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 8) begin n_fail++; $display("FAIL full_count: got %0d writes, expected 8", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size() && i < 8; i++) begin
            n_checks++;
            if (wa_addr[i] !== 4'(8 + i) || wa_data[i] !== exp_q[i])
                begin n_fail++; $display("FAIL full_write[%0d]: got %h@%0d, expected %h@%0d", i, wa_data[i], wa_addr[i], exp_q[i], 8 + i); end
        end
        n_checks++;
        if (done_a != 1 || err_a != 0 || rd_buffer_a !== 1'b1 || frame_count_a !== 16'd1)
            begin n_fail++; $display("FAIL full_commit: got done=%0d err=%0d rd=%b fc=%0d, expected 1 0 1 1", done_a, err_a, rd_buffer_a, frame_count_a); end
    endtask

    task automatic test_second_frame();
        clear_obs();
        send_line(8, 2); send_line(8, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 8) begin n_fail++; $display("FAIL second_count: got %0d writes, expected 8", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size() && i < 8; i++) begin
            n_checks++;
            if (wa_addr[i] !== 4'(i) || wa_data[i] !== exp_q[i])
                begin n_fail++; $display("FAIL second_write[%0d]: got %h@%0d, expected %h@%0d", i, wa_data[i], wa_addr[i], exp_q[i], i); end
        end
        n_checks++;
        if (done_a != 1 || err_a != 0 || rd_buffer_a !== 1'b0 || frame_count_a !== 16'd2)
            begin n_fail++; $display("FAIL second_commit: got done=%0d err=%0d rd=%b fc=%0d, expected 1 0 0 2", done_a, err_a, rd_buffer_a, frame_count_a); end
    endtask

    task automatic test_short_frame();
        clear_obs();
        send_line(8, 2); send_line(6, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 7) begin n_fail++; $display("FAIL short_count: got %0d writes, expected 7", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size() && i < 7; i++) begin
            n_checks++;
            if (wa_addr[i] !== 4'(8 + i) || wa_data[i] !== exp_q[i])
                begin n_fail++; $display("FAIL short_write[%0d]: got %h@%0d, expected %h@%0d", i, wa_data[i], wa_addr[i], exp_q[i], 8 + i); end
        end
        n_checks++;
        if (done_a != 0 || err_a != 1 || rd_buffer_a !== 1'b0 || frame_count_a !== 16'd2)
            begin n_fail++; $display("FAIL short_commit: got done=%0d err=%0d rd=%b fc=%0d, expected 0 1 0 2", done_a, err_a, rd_buffer_a, frame_count_a); end
    endtask

    task automatic test_long_frame();
        clear_obs();
        send_line(8, 2); send_line(10, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 8) begin n_fail++; $display("FAIL long_count: got %0d writes, expected 8", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size() && i < 8; i++) begin
            n_checks++;
            if (wa_addr[i] !== 4'(8 + i) || wa_data[i] !== exp_q[i])
                begin n_fail++; $display("FAIL long_write[%0d]: got %h@%0d, expected %h@%0d", i, wa_data[i], wa_addr[i], exp_q[i], 8 + i); end
        end
        n_checks++;
        if (done_a != 0 || err_a != 1 || rd_buffer_a !== 1'b0 || frame_count_a !== 16'd2)
            begin n_fail++; $display("FAIL long_commit: got done=%0d err=%0d rd=%b fc=%0d, expected 0 1 0 2", done_a, err_a, rd_buffer_a, frame_count_a); end
    endtask

    task automatic test_odd_bytes();
        clear_obs();
        send_line(3, 2); send_line(8, 2); send_line(6, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 8) begin n_fail++; $display("FAIL odd_count: got %0d writes, expected 8", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size() && i < 8; i++) begin
            n_checks++;
            if (wa_addr[i] !== 4'(8 + i) || wa_data[i] !== exp_q[i])
                begin n_fail++; $display("FAIL odd_write[%0d]: got %h@%0d, expected %h@%0d", i, wa_data[i], wa_addr[i], exp_q[i], 8 + i); end
        end
        n_checks++;
        if (done_a != 1 || err_a != 0 || rd_buffer_a !== 1'b1 || frame_count_a !== 16'd3)
            begin n_fail++; $display("FAIL odd_commit: got done=%0d err=%0d rd=%b fc=%0d, expected 1 0 1 3", done_a, err_a, rd_buffer_a, frame_count_a); end
    endtask

    task automatic test_enable_low();
        clear_obs();
        enable_i = 1'b0;
        send_line(8, 2); send_line(8, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 8) begin n_fail++; $display("FAIL enlow_count: got %0d writes, expected 8", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size() && i < 8; i++) begin
            n_checks++;
            if (wa_addr[i] !== 4'(i) || wa_data[i] !== exp_q[i])
                begin n_fail++; $display("FAIL enlow_write[%0d]: got %h@%0d, expected %h@%0d", i, wa_data[i], wa_addr[i], exp_q[i], i); end
        end
        n_checks++;
        if (done_a != 1 || rd_buffer_a !== 1'b0 || frame_count_a !== 16'd4)
            begin n_fail++; $display("FAIL enlow_commit: got done=%0d rd=%b fc=%0d, expected 1 0 4", done_a, rd_buffer_a, frame_count_a); end
        clear_obs();
        send_line(8, 2); send_line(8, 2);
        vsync_pulse();
        n_checks++;
        if (wa_addr.size() != 0 || done_a != 0 || err_a != 0 || frame_count_a !== 16'd4)
            begin n_fail++; $display("FAIL disabled_idle: got writes=%0d done=%0d err=%0d fc=%0d, expected 0 0 0 4", wa_addr.size(), done_a, err_a, frame_count_a); end
    endtask

    task automatic test_one_byte_mode();
        reset_i = 1'b1; clks(2);
        reset_i = 1'b0; enable_i = 1'b1; clks(2);
        vsync_pulse();
        clear_obs();
        send_line(4, 1); send_line(4, 1);
        vsync_pulse();
        n_checks++;
        if (wb_addr.size() != 8) begin n_fail++; $display("FAIL grey_count: got %0d writes, expected 8", wb_addr.size()); end
        for (int i = 0; i < wb_addr.size() && i < 8; i++) begin
            n_checks++;
            if (wb_addr[i] !== 3'(i) || wb_data[i] !== exp_q[i][7:0])
                begin n_fail++; $display("FAIL grey_write[%0d]: got %h@%0d, expected %h@%0d", i, wb_data[i], wb_addr[i], exp_q[i][7:0], i); end
        end
        n_checks++;
        if (done_b != 1 || err_b != 0 || rd_buffer_b !== 1'b0 || frame_count_b !== 16'd1)
            begin n_fail++; $display("FAIL grey_commit: got done=%0d err=%0d rd=%b fc=%0d, expected 1 0 0 1", done_b, err_b, rd_buffer_b, frame_count_b); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        send_line(4, 1);
        n_checks++;
        if (wb_addr.size() != 4) begin n_fail++; $display("FAIL midrst_partial: got %0d writes, expected 4", wb_addr.size()); end
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (frame_count_b !== 16'd0 || rd_buffer_b !== 1'b0 || rd_buffer_a !== 1'b0 || wr_addr_b !== 3'd0)
            begin n_fail++; $display("FAIL midrst_async: got fc=%0d rdb=%b rda=%b addr=%0d, expected 0", frame_count_b, rd_buffer_b, rd_buffer_a, wr_addr_b); end
        clks(3);
        reset_i = 1'b0;
        clks(2);
        clear_obs();
        send_line(8, 1);
        vsync_pulse();
        n_checks++;
        if (wb_addr.size() != 0 || done_b != 0 || err_b != 0 || frame_count_b !== 16'd0)
            begin n_fail++; $display("FAIL midrst_idle: got writes=%0d done=%0d err=%0d fc=%0d, expected 0 0 0 0", wb_addr.size(), done_b, err_b, frame_count_b); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_second_frame();
        test_short_frame();
        test_long_frame();
        test_odd_bytes();
        test_enable_low();
        test_one_byte_mode();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmos_frame_writer.md
# cmos_frame_writer

Parametrised camera-capture write engine. It samples the raw CMOS sensor bus (PCLK, VSYNC, HREF, D[7:0]) in the `clk_i` domain and packs 1 or 2 bytes into a pixel. It generates linear frame-buffer write addresses and delivers frames whole, with optional double buffering, so the display side never reads a half-written frame. It sits between the sensor pins and the dual-port VRAM and drives the VRAM write port directly.

## Interface
Parameters:
- `H_ACTIVE`, default 320: pixels per line.
- `V_ACTIVE`, default 240: lines per frame.
- `BYTES_PER_PIXEL`, default 2: 1 (grey/raw) or 2 (RGB565). `PIXEL_WIDTH = 8*BYTES_PER_PIXEL`.
- `NUM_BUFFERS`, default 2: 1 or 2 frame buffers. `FRAME_PIXELS = H_ACTIVE*V_ACTIVE`. `ADDR_WIDTH = $clog2(FRAME_PIXELS*NUM_BUFFERS)`.

Ports:
- `clk_i` in 1: system clock; must be ≥ 4× PCLK.
- `reset_i` in 1: asynchronous, active-high reset.
- `enable_i` in 1: capture enable; sampled only at frame start.
- `pclk_cmos_i`, `vsync_cmos_i`, `href_cmos_i` in 1: raw sensor strobes.
- `pixel_data_cmos_i` in 8: raw sensor data.
- `wr_en_o` out 1: VRAM write strobe.
- `wr_addr_o` out ADDR_WIDTH: VRAM write address.
- `wr_data_o` out PIXEL_WIDTH: packed pixel; the first byte received goes in the MSBs.
- `rd_buffer_o` out 1: buffer the display must read; always 0 when `NUM_BUFFERS=1`.
- `frame_done_o` out 1: one-cycle pulse when a complete frame is committed.
- `frame_error_o` out 1: one-cycle pulse when a frame ends short or long.
- `frame_count_o` out 16: count of committed frames; wraps at 0xFFFF→0.

## Operation
- Input sync: all four sensor inputs pass through 2 flops. PCLK and VSYNC have a third flop for edge detection.
  - `pclk_rise = s2 & ~s3`.
  - `vsync_rise` and `vsync_fall` are derived the same way.
  - Data and HREF are used at their s2 stage on the `pclk_rise` cycle.
- FSM states:
  - WAIT_VSYNC (reset state): ignore all bytes. `vsync_rise` → BLANK.
  - BLANK: `vsync_fall` with `enable_i`=1 → ACTIVE, clearing the pixel counter, byte phase and `overflow`. `vsync_fall` with `enable_i`=0 → stay in BLANK.
  - ACTIVE: on `pclk_rise` with HREF=1, capture one byte. When the byte phase reaches `BYTES_PER_PIXEL`, issue a write.
  - ACTIVE, `vsync_rise`: if pixel counter == FRAME_PIXELS and `overflow`=0, pulse `frame_done_o`, increment `frame_count_o`, and toggle the write/read buffers (2-buffer mode only). Otherwise pulse `frame_error_o` and do not toggle. In both cases → BLANK.
- Byte phase resets to 0 on the HREF falling edge (s2 vs. its previous value). An incomplete trailing pixel is dropped and is not written.
- Address: `wr_addr_o = wbuf*FRAME_PIXELS + pixel_counter`, where `wbuf = ~rd_buffer_o` in 2-buffer mode and 0 in 1-buffer mode.
  - The pixel counter increments after each write.
  - Once the counter equals FRAME_PIXELS, further pixels are not written, the counter holds, and the internal `overflow` flag is set.
  - A write never goes outside the current buffer.

## Timing
- Reset values: every output is 0, the FSM is in WAIT_VSYNC, all counters and sync flops are 0, and `rd_buffer_o`=0 (write buffer = 1 in 2-buffer mode).
- Pin-to-edge latency: 3 `clk_i` cycles from a PCLK pin rise to the `pclk_rise` cycle.
- Write latency: `wr_en_o` is high for exactly 1 cycle, the cycle after the `pclk_rise` that captured the final byte of the pixel. Address and data are valid in that same cycle.
- Frame commit: `frame_done_o`/`frame_error_o` and the `rd_buffer_o` toggle occur 1 cycle after the `vsync_rise` detection.
- Simultaneous events: `vsync_rise` has priority over `pclk_rise` in the same cycle; that byte is discarded.
- `enable_i` falling mid-frame: the current frame completes normally; the FSM then stays in BLANK.
- `reset_i` mid-frame: immediate return to WAIT_VSYNC. The partial frame is never committed and `rd_buffer_o` returns to 0.

## Test plan
- Reset → idle: assert reset, drive 10 PCLK cycles with HREF=1 before any VSYNC → `wr_en_o` stays 0, all outputs 0.
- Full RGB565 frame (H=4, V=2 for sim), bytes 0x12,0x34,… →
  - 8 writes with `wr_data_o` 0x1234, 0x5678, … at addresses 8..15;
  - then `frame_done_o` pulse, `rd_buffer_o`=1, `frame_count_o`=1.
- Second frame → writes at addresses 0..7, `rd_buffer_o` back to 0, `frame_count_o`=2.
- Short frame (7 pixels) → `frame_error_o` pulse, no `rd_buffer_o` toggle, count unchanged. Long frame (9 pixels) → only 8 writes, then `frame_error_o`.
- Odd byte count: 3 bytes on one HREF line → 1 write only; the next line starts at phase 0, giving correct MSB alignment.
- 1-byte mode, `NUM_BUFFERS=1`: 8-byte frame → writes at addresses 0..7 with the raw bytes; `rd_buffer_o` stays 0. Reset asserted mid-frame → no commit pulses, FSM back in WAIT_VSYNC.
